fb_fetch_arbiter: RTL

Shares the single-port Game Boy framebuffer RAM (160x144, 2 bpp) between the PPU write port and display line prefetch. Driven by the panel timing generator's row events, it copies each upcoming GB line into a ping-pong line buffer one display row before that line is first shown. The line is shown SCALE times vertically, with a letterbox offset on the 480-row panel.

---
 rtl/fb_fetch_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_fetch_arbiter.sv
// Framebuffer RAM arbiter: shares the single RAM port between PPU writes and
// display line prefetch into a ping-pong line buffer, driven by panel row events.
module fb_fetch_arbiter #(
    parameter int unsigned GB_W     = 160,
    parameter int unsigned GB_H     = 144,
    parameter int unsigned SCALE    = 3,
    parameter int unsigned V_OFFSET = 24,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [9:0]        row,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data,
    output logic              wr_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [7:0]        lb_addr,
    output logic [1:0]        lb_data,
    output logic              line_ready,
    output logic              disp_bank,
    output logic              busy,
    output logic              underrun
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]        state_q, state_d, st_eff;
    logic [7:0]        x_q, x_d;
    logic [ADDR_W-1:0] fetch_base_q, fetch_base_d;
    logic              fetch_bank_q, fetch_bank_d;
    logic [9:0]        next_trig_q, next_trig_d, nt_eff;
    logic [7:0]        gb_line_q, gb_line_d, gl_eff;
    logic [ADDR_W-1:0] line_base_q, line_base_d, lb_base_eff;
    logic              last_wr_q, last_wr_d;

    // Read pipeline: issue stage (RAM strobe cycle), then data-return stage.
    logic              rd_v_q, rd_v_d;
    logic [7:0]        rd_idx_q, rd_idx_d;
    logic              rd_bank_q, rd_bank_d;
    logic              p1_v_q, p1_v_d;
    logic [7:0]        p1_idx_q;
    logic              p1_bank_q;

    logic              wr_ack_q, wr_ack_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [1:0]        ram_wdata_q, ram_wdata_d;
    logic              lb_we_q, lb_we_d;
    logic              lb_bank_q, lb_bank_d;
    logic [7:0]        lb_addr_q, lb_addr_d;
    logic [1:0]        lb_data_q, lb_data_d;
    logic              line_ready_q, line_ready_d;
    logic              disp_bank_q, disp_bank_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;

    logic              trigger, abort, rd_pend, wr_pend, grant_wr, grant_rd;
    logic [ADDR_W-1:0] rd_base;
    logic [7:0]        rd_x;
    logic              rd_bank;

    always_comb begin
        // frame_start takes effect before the trigger is evaluated.
        nt_eff      = frame_start ? 10'(V_OFFSET - 1) : next_trig_q;
        gl_eff      = frame_start ? 8'd0 : gb_line_q;
        lb_base_eff = frame_start ? '0 : line_base_q;
        st_eff      = frame_start ? StIdle : state_q;

        trigger = line_start && (row == nt_eff) && (gl_eff < 8'(GB_H));
        abort   = frame_start || trigger;

        rd_pend = trigger || (st_eff == StFetch);
        rd_base = trigger ? lb_base_eff : fetch_base_q;
        rd_x    = trigger ? 8'd0 : x_q;
        rd_bank = trigger ? gl_eff[0] : fetch_bank_q;

        // The cycle carrying wr_ack still sees the old request held high.
        wr_pend  = wr_req && !wr_ack_q;
        grant_wr = wr_pend && (!rd_pend || !last_wr_q);
        grant_rd = rd_pend && !grant_wr;

        state_d      = st_eff;
        x_d          = x_q;
        fetch_base_d = fetch_base_q;
        fetch_bank_d = fetch_bank_q;
        next_trig_d  = nt_eff;
        gb_line_d    = gl_eff;
        line_base_d  = lb_base_eff;

        if (trigger) begin
            state_d      = StFetch;
            x_d          = 8'd0;
            fetch_base_d = lb_base_eff;
            fetch_bank_d = gl_eff[0];
            next_trig_d  = nt_eff + 10'(SCALE);
            gb_line_d    = gl_eff + 8'd1;
            line_base_d  = lb_base_eff + ADDR_W'(GB_W);
        end
        if (grant_rd) begin
            x_d = rd_x + 8'd1;
            if (rd_x == 8'(GB_W - 1)) begin
                state_d = StDrain;
            end
        end

        last_wr_d = grant_wr ? 1'b1 : (grant_rd ? 1'b0 : last_wr_q);

        wr_ack_d    = grant_wr;
        ram_en_d    = grant_wr || grant_rd;
        ram_we_d    = grant_wr;
        ram_addr_d  = grant_wr ? wr_addr : (rd_base + ADDR_W'(rd_x));
        ram_wdata_d = grant_wr ? wr_data : 2'b00;

        rd_v_d    = grant_rd;
        rd_idx_d  = rd_x;
        rd_bank_d = rd_bank;
        // Any abort discards data still in flight for the old line.
        p1_v_d    = rd_v_q && !abort;
        lb_we_d   = p1_v_q && !abort;
        lb_addr_d = lb_we_d ? p1_idx_q : lb_addr_q;
        lb_bank_d = lb_we_d ? p1_bank_q : lb_bank_q;
        lb_data_d = lb_we_d ? ram_rdata : lb_data_q;

        line_ready_d = lb_we_d && (p1_idx_q == 8'(GB_W - 1));
        disp_bank_d  = line_ready_d ? p1_bank_q : disp_bank_q;
        if (line_ready_d) begin
            state_d = StIdle;
        end

        busy_d     = (state_d != StIdle);
        underrun_d = frame_start ? 1'b0 : underrun_q;
        if (trigger && !frame_start && (state_q != StIdle)) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            x_q          <= '0;
            fetch_base_q <= '0;
            fetch_bank_q <= 1'b0;
            next_trig_q  <= 10'(V_OFFSET - 1);
            gb_line_q    <= '0;
            line_base_q  <= '0;
            last_wr_q    <= 1'b0;
            rd_v_q       <= 1'b0;
            rd_idx_q     <= '0;
            rd_bank_q    <= 1'b0;
            p1_v_q       <= 1'b0;
            p1_idx_q     <= '0;
            p1_bank_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            lb_we_q      <= 1'b0;
            lb_bank_q    <= 1'b0;
            lb_addr_q    <= '0;
            lb_data_q    <= '0;
            line_ready_q <= 1'b0;
            disp_bank_q  <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            fetch_base_q <= fetch_base_d;
            fetch_bank_q <= fetch_bank_d;
            next_trig_q  <= next_trig_d;
            gb_line_q    <= gb_line_d;
            line_base_q  <= line_base_d;
            last_wr_q    <= last_wr_d;
            rd_v_q       <= rd_v_d;
            rd_idx_q     <= rd_idx_d;
            rd_bank_q    <= rd_bank_d;
            p1_v_q       <= p1_v_d;
            p1_idx_q     <= rd_idx_q;
            p1_bank_q    <= rd_bank_q;
            wr_ack_q     <= wr_ack_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            lb_we_q      <= lb_we_d;
            lb_bank_q    <= lb_bank_d;
            lb_addr_q    <= lb_addr_d;
            lb_data_q    <= lb_data_d;
            line_ready_q <= line_ready_d;
            disp_bank_q  <= disp_bank_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign lb_we      = lb_we_q;
    assign lb_bank    = lb_bank_q;
    assign lb_addr    = lb_addr_q;
    assign lb_data    = lb_data_q;
    assign line_ready = line_ready_q;
    assign disp_bank  = disp_bank_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule
